// File: rtl/rotary_quad_ctrl.sv
// Rotary encoder front end for a frequency-word register.
// Quadrature detents move an internal count by a selectable step inside
// mode-dependent bounds. The count is published on Address once per update
// period, and FreqChng flags each published value that differs from the last.
module rotary_quad_ctrl #(
    parameter int         CNT_W       = 11,
    parameter int         CNT_MAX     = 1800,
    parameter int         CNT_MIN_ALT = 800,
    parameter logic [2:0] ALT_MODE    = 3'd4,
    parameter int         STEP_0      = 1,
    parameter int         STEP_1      = 10,
    parameter int         STEP_2      = 100,
    parameter int         UPD_PERIOD  = 2400,
    parameter int         DEB_CYC     = 16,
    parameter int         WRAP        = 0
) (
    input  logic             Fg_CLK,
    input  logic             RESET,
    input  logic             Rot_A,
    input  logic             Rot_B,
    input  logic             Rot_C,
    input  logic [2:0]       Mode,
    output logic [CNT_W-1:0] Address,
    output logic             FreqChng,
    output logic [1:0]       StepSel,
    output logic             Dir
);

    // One extra bit of headroom so that sums and differences never alias.
    localparam int EW = CNT_W + 1;
    localparam int PW = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [EW-1:0] MAX_E  = EW'(CNT_MAX);
    localparam logic [EW-1:0] MIN_E  = EW'(CNT_MIN_ALT);
    localparam logic [PW-1:0] PER_LAST = PW'(UPD_PERIOD - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       sync_c;
    logic             a_fall;
    logic             b_fall;
    logic             c_level;

    logic [DW-1:0]    deb_cnt;
    logic             deb_btn;
    logic [1:0]       step_sel;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             dir_q;
    logic             dir_d;

    logic [EW-1:0]    step_e;
    logic [EW-1:0]    lb_e;
    logic [EW-1:0]    count_e;
    logic [EW-1:0]    up_e;
    logic [EW-1:0]    dn_e;
    logic             alt_clamp;

    logic [PW-1:0]    per_cnt;
    logic             tick;

    // Three-flop synchronisers; the encoder phases idle high, the button idles low.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
            sync_c <= 3'b000;
        end else begin
            sync_a <= {sync_a[1:0], Rot_A};
            sync_b <= {sync_b[1:0], Rot_B};
            sync_c <= {sync_c[1:0], Rot_C};
        end
    end

    assign a_fall  = sync_a[2] & ~sync_a[1];
    assign b_fall  = sync_b[2] & ~sync_b[1];
    assign c_level = sync_c[2];

    // Button debounce: accept a new level only after it has held for DEB_CYC cycles; each accepted press cycles the step index.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            deb_cnt  <= '0;
            deb_btn  <= 1'b0;
            step_sel <= 2'd0;
        end else if (c_level != deb_btn) begin
            if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                deb_btn <= c_level;
                if (c_level) begin
                    step_sel <= (step_sel == 2'd2) ? 2'd0 : step_sel + 2'd1;
                end
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // Candidate up/down results with bound handling, computed on the widened count.
    always_comb begin
        case (step_sel)
            2'd1:    step_e = EW'(STEP_1);
            2'd2:    step_e = EW'(STEP_2);
            default: step_e = EW'(STEP_0);
        endcase
        lb_e      = (Mode == ALT_MODE) ? MIN_E : '0;
        count_e   = {1'b0, count_q};
        alt_clamp = (Mode == ALT_MODE) && (count_e < MIN_E);
        up_e      = count_e + step_e;
        if (up_e > MAX_E) begin
            up_e = (WRAP != 0) ? lb_e : MAX_E;
        end
        if (count_e < lb_e + step_e) begin
            dn_e = (WRAP != 0) ? MAX_E : lb_e;
        end else begin
            dn_e = count_e - step_e;
        end
    end

    // Detent FSM next state: the leading phase fall moves the count, the trailing fall re-arms.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        if (alt_clamp) begin
            count_d = CNT_W'(MIN_E);
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (b_fall && !a_fall) begin
                        count_d = CNT_W'(up_e);
                        dir_d   = 1'b1;
                        state_d = UP;
                    end else if (a_fall && !b_fall) begin
                        count_d = CNT_W'(dn_e);
                        dir_d   = 1'b0;
                        state_d = DOWN;
                    end
                end
                UP: begin
                    if (a_fall) begin
                        state_d = IDLE;
                    end
                end
                DOWN: begin
                    if (b_fall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Detent FSM, count and direction registers.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    assign tick = (per_cnt == PER_LAST);

    // Free-running update period counter.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Publish the count once per period and flag only genuine changes.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            Address  <= '0;
            FreqChng <= 1'b0;
        end else if (tick) begin
            Address  <= count_q;
            FreqChng <= (Address != count_q);
        end else begin
            FreqChng <= 1'b0;
        end
    end

    assign StepSel = step_sel;
    assign Dir     = dir_q;

endmodule

// File: tb/tb_rotary_quad_ctrl.sv
// Scoreboard bench for rotary_quad_ctrl: a saturating and a wrapping instance
// share the same encoder stimulus; each published Address is matched against
// hand-computed values queued by the stimulus process.
module tb_rotary_quad_ctrl;

    localparam int UPD = 2400;

    logic        fg_clk = 1'b0;
    logic        rst;
    logic        rot_a;
    logic        rot_b;
    logic        rot_c;
    logic [2:0]  mode;
    logic [10:0] addr0;
    logic        fc0;
    logic [1:0]  ss0;
    logic        dir0;
    logic [10:0] addr1;
    logic        fc1;
    logic [1:0]  ss1;
    logic        dir1;

    int          vectors     = 0;
    int          miscompares = 0;
    int          tb_per;
    logic [10:0] q0[$];
    logic [10:0] q1[$];

    rotary_quad_ctrl dut (
        .Fg_CLK(fg_clk), .RESET(rst), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_C(rot_c),
        .Mode(mode), .Address(addr0), .FreqChng(fc0), .StepSel(ss0), .Dir(dir0)
    );

    rotary_quad_ctrl #(.WRAP(1)) dut_w (
        .Fg_CLK(fg_clk), .RESET(rst), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_C(rot_c),
        .Mode(mode), .Address(addr1), .FreqChng(fc1), .StepSel(ss1), .Dir(dir1)
    );

    // Free-running clock.
    always #5 fg_clk = ~fg_clk;

    // Bench-side phase reference for the publish period.
    always @(posedge fg_clk or posedge rst) begin
        if (rst) tb_per <= 0;
        else if (tb_per == UPD - 1) tb_per <= 0;
        else tb_per <= tb_per + 1;
    end

    // Monitor: every FreqChng pulse must match the next queued Address.
    always @(negedge fg_clk) begin
        logic [10:0] exp_v;
        if (!rst && fc0) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pulse_sat: unexpected FreqChng, Address %0d, none expected", addr0);
            end else begin
                exp_v = q0.pop_front();
                if (addr0 !== exp_v) begin
                    miscompares++;
                    $display("[TB] FAIL addr_sat: got %0d, expected %0d", addr0, exp_v);
                end
            end
        end
        if (!rst && fc1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pulse_wrap: unexpected FreqChng, Address %0d, none expected", addr1);
            end else begin
                exp_v = q1.pop_front();
                if (addr1 !== exp_v) begin
                    miscompares++;
                    $display("[TB] FAIL addr_wrap: got %0d, expected %0d", addr1, exp_v);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic c, input int cyc);
        rot_a = a;
        rot_b = b;
        rot_c = c;
        repeat (cyc) @(negedge fg_clk);
    endtask

    task automatic detentUp();
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
    endtask

    task automatic detentDown();
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
    endtask

    task automatic press();
        applyStimulus(1'b1, 1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 30);
    endtask

    task automatic publish(input logic p0, input int v0, input logic p1, input int v1);
        if (p0) q0.push_back(11'(v0));
        if (p1) q1.push_back(11'(v1));
    endtask

    // Wait for the next publish edge, then confirm every queued value was seen.
    task automatic waitUpdate();
        int n = 0;
        do begin
            @(negedge fg_clk);
            n++;
        end while (tb_per != 0 && n < UPD + 4);
        if (tb_per != 0) checkOutput("tick_timeout", tb_per, 0);
        repeat (3) @(negedge fg_clk);
        checkOutput("pending_sat", q0.size(), 0);
        checkOutput("pending_wrap", q1.size(), 0);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        repeat (3) @(negedge fg_clk);
        rst = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        rst   = 1'b1;
        rot_a = 1'b1;
        rot_b = 1'b1;
        rot_c = 1'b0;
        mode  = 3'd0;
        repeat (3) @(negedge fg_clk);
        rst = 1'b0;
        @(negedge fg_clk);

        checkOutput("rst_addr_sat", addr0, 0);
        checkOutput("rst_fc_sat", fc0, 0);
        checkOutput("rst_step_sat", ss0, 0);
        checkOutput("rst_dir_sat", dir0, 0);
        checkOutput("rst_addr_wrap", addr1, 0);
        checkOutput("rst_dir_wrap", dir1, 0);

        // Single up detent, step 1.
        detentUp();
        publish(1'b1, 1, 1'b1, 1);
        waitUpdate();
        checkOutput("dir_up_sat", dir0, 1);
        checkOutput("dir_up_wrap", dir1, 1);

        // Simultaneous falls change nothing; +1 then -1 nets to no publish.
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8);
        checkOutput("dir_simul_sat", dir0, 1);
        detentUp();
        detentDown();
        waitUpdate();
        checkOutput("dir_down_sat", dir0, 0);
        checkOutput("dir_down_wrap", dir1, 0);

        // Button debounce boundary and step index cycling.
        applyStimulus(1'b1, 1'b1, 1'b1, 15);
        applyStimulus(1'b1, 1'b1, 1'b0, 30);
        checkOutput("step_glitch", ss0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16);
        applyStimulus(1'b1, 1'b1, 1'b0, 30);
        checkOutput("step_one_press", ss0, 1);
        press();
        checkOutput("step_two_press", ss1, 2);
        press();
        checkOutput("step_three_press", ss0, 0);

        // Count to 5, then the raised lower bound lifts it to 800.
        repeat (4) detentUp();
        publish(1'b1, 5, 1'b1, 5);
        waitUpdate();
        mode = 3'd4;
        repeat (4) @(negedge fg_clk);
        publish(1'b1, 800, 1'b1, 800);
        waitUpdate();
        press();
        press();
        checkOutput("step_alt", ss0, 2);
        detentDown();
        publish(1'b0, 0, 1'b1, 1800);
        waitUpdate();
        checkOutput("dir_alt_sat", dir0, 0);
        mode = 3'd0;

        // Upper bound: build 1750, then one 100-step up.
        resetPulse();
        checkOutput("rst2_step_sat", ss0, 0);
        checkOutput("rst2_addr_wrap", addr1, 0);
        press();
        press();
        repeat (17) detentUp();
        press();
        press();
        repeat (5) detentUp();
        press();
        checkOutput("step_top", ss0, 2);
        publish(1'b1, 1750, 1'b1, 1750);
        waitUpdate();
        detentUp();
        publish(1'b1, 1800, 1'b1, 0);
        waitUpdate();
        checkOutput("dir_top_sat", dir0, 1);
        detentDown();
        publish(1'b1, 1700, 1'b1, 1800);
        waitUpdate();

        // Reset while parked in UP at count 37.
        resetPulse();
        press();
        repeat (3) detentUp();
        press();
        press();
        repeat (6) detentUp();
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        publish(1'b1, 37, 1'b1, 37);
        waitUpdate();
        #3;
        rst   = 1'b1;
        rot_b = 1'b1;
        #1;
        checkOutput("async_addr_sat", addr0, 0);
        checkOutput("async_dir_sat", dir0, 0);
        checkOutput("async_addr_wrap", addr1, 0);
        checkOutput("async_dir_wrap", dir1, 0);
        checkOutput("async_fc_sat", fc0, 0);
        repeat (3) @(negedge fg_clk);
        rst = 1'b0;
        repeat (4) @(negedge fg_clk);
        detentUp();
        publish(1'b1, 1, 1'b1, 1);
        waitUpdate();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
